cpu_sequencer: RTL and testbench

Instruction-cycle controller for the 8-bit RISC core.
- Sequences fetch, decode and execute for the 3-bit opcode set: HLT 000, SKZ 001, ADD 010, AND 011, XOR 100, LDA 101, STO 110, JMP 111.
- Drives PC, instruction register, accumulator load, ALU enable and the memory read/write strobes.
- Stalls on a memory-ready handshake.
- Sits between the instruction register/ALU/accumulator and the memory bus.

---
 rtl/cpu_sequencer.sv | 170 +++++++++++++++++
 tb/tb_cpu_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Instruction-cycle controller for the 8-bit RISC core: fetch/decode/execute
// sequencing with memory-ready stalls, halt/resume and a retired-instruction counter.
module cpu_sequencer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             resume,
    input  logic [2:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             rd,
    output logic             wr,
    output logic             load_ir,
    output logic             inc_pc,
    output logic             load_pc,
    output logic             load_acc,
    output logic             alu_en,
    output logic             datactl_ena,
    output logic             halt,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_F0   = 3'd1,
        S_F1   = 3'd2,
        S_DEC  = 3'd3,
        S_EX0  = 3'd4,
        S_EX1  = 3'd5,
        S_EX2  = 3'd6,
        S_HALT = 3'd7
    } state_t;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    state_t           state_q;
    state_t           state_d;
    logic [2:0]       op_q;
    logic             zero_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_inc;

    assign state       = state_q;
    assign instr_count = cnt_q;

    // State, latched instruction fields and retired-instruction counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= 3'b000;
            zero_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DEC) begin
                op_q   <= opcode;
                zero_q <= zero;
            end
            if (cnt_inc) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Next state and control strobes; memory states hold until mem_ready
    always_comb begin
        state_d     = state_q;
        cnt_inc     = 1'b0;
        rd          = 1'b0;
        wr          = 1'b0;
        load_ir     = 1'b0;
        inc_pc      = 1'b0;
        load_pc     = 1'b0;
        load_acc    = 1'b0;
        alu_en      = 1'b0;
        datactl_ena = 1'b0;
        halt        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ena) state_d = S_F0;
            end
            S_F0: begin
                rd      = 1'b1;
                load_ir = 1'b1;
                if (mem_ready) state_d = S_F1;
            end
            S_F1: begin
                rd      = 1'b1;
                load_ir = 1'b1;
                inc_pc  = mem_ready;
                if (mem_ready) state_d = S_DEC;
            end
            S_DEC: begin
                alu_en  = 1'b1;
                state_d = S_EX0;
            end
            S_EX0: begin
                case (op_q)
                    OP_HLT: begin
                        halt    = 1'b1;
                        cnt_inc = 1'b1;
                        state_d = S_HALT;
                    end
                    OP_SKZ: begin
                        inc_pc  = zero_q;
                        state_d = S_EX1;
                    end
                    OP_ADD, OP_AND, OP_XOR, OP_LDA: begin
                        rd = 1'b1;
                        if (mem_ready) state_d = S_EX1;
                    end
                    OP_STO: begin
                        datactl_ena = 1'b1;
                        state_d     = S_EX1;
                    end
                    OP_JMP: begin
                        load_pc = 1'b1;
                        state_d = S_EX1;
                    end
                    default: state_d = S_EX1;
                endcase
            end
            S_EX1: begin
                case (op_q)
                    OP_SKZ: begin
                        inc_pc  = zero_q;
                        state_d = S_EX2;
                    end
                    OP_ADD, OP_AND, OP_XOR, OP_LDA: begin
                        rd       = 1'b1;
                        load_acc = mem_ready;
                        if (mem_ready) state_d = S_EX2;
                    end
                    OP_STO: begin
                        wr          = 1'b1;
                        datactl_ena = 1'b1;
                        if (mem_ready) state_d = S_EX2;
                    end
                    OP_JMP: begin
                        load_pc = 1'b1;
                        state_d = S_EX2;
                    end
                    default: state_d = S_EX2;
                endcase
            end
            S_EX2: begin
                datactl_ena = (op_q == OP_STO);
                cnt_inc     = 1'b1;
                state_d     = ena ? S_F0 : S_IDLE;
            end
            S_HALT: begin
                halt = 1'b1;
                if (resume) state_d = ena ? S_F0 : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboarded random bench for cpu_sequencer: an instruction-level model queues
// the expected per-cycle state/strobes/count, a negedge monitor pops and compares.
module tb_cpu_sequencer;

    localparam int unsigned CW = 4;

    localparam logic [2:0] HLT = 3'b000;
    localparam logic [2:0] SKZ = 3'b001;
    localparam logic [2:0] ADD = 3'b010;
    localparam logic [2:0] AND = 3'b011;
    localparam logic [2:0] XOR = 3'b100;
    localparam logic [2:0] LDA = 3'b101;
    localparam logic [2:0] STO = 3'b110;
    localparam logic [2:0] JMP = 3'b111;

    // bit order: rd wr load_ir inc_pc load_pc load_acc alu_en datactl_ena halt
    localparam logic [8:0] QUAL_MASK = 9'b111010111;

    logic          clk;
    logic          rst_n;
    logic          ena;
    logic          resume;
    logic [2:0]    opcode;
    logic          zero;
    logic          mem_ready;
    logic          rd;
    logic          wr;
    logic          load_ir;
    logic          inc_pc;
    logic          load_pc;
    logic          load_acc;
    logic          alu_en;
    logic          datactl_ena;
    logic          halt;
    logic [2:0]    state;
    logic [CW-1:0] instr_count;

    cpu_sequencer #(.CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .resume      (resume),
        .opcode      (opcode),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .rd          (rd),
        .wr          (wr),
        .load_ir     (load_ir),
        .inc_pc      (inc_pc),
        .load_pc     (load_pc),
        .load_acc    (load_acc),
        .alu_en      (alu_en),
        .datactl_ena (datactl_ena),
        .halt        (halt),
        .state       (state),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]    st;
        logic [8:0]    ctl;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          sb[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    logic [CW-1:0] m_cnt;
    logic [2:0]    cur_st;

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [8:0] mk(input logic r, w, ir, inc, lpc, lacc, alu, dct, hl);
        return {r, w, ir, inc, lpc, lacc, alu, dct, hl};
    endfunction

    // Monitor: compare every queued cycle expectation against the DUT
    always @(negedge clk) begin
        exp_t e;
        logic [8:0] act;
        cyc++;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            act = {rd, wr, load_ir, inc_pc, load_pc, load_acc, alu_en, datactl_ena, halt};
            n_tests++;
            if (state !== e.st) begin
                n_fail++;
                $display("FAIL state cyc=%0d got=%0d exp=%0d", cyc, state, e.st);
            end
            n_tests++;
            if (act !== e.ctl) begin
                n_fail++;
                $display("FAIL ctl cyc=%0d st=%0d got=%b exp=%b", cyc, e.st, act, e.ctl);
            end
            n_tests++;
            if (instr_count !== e.cnt) begin
                n_fail++;
                $display("FAIL instr_count cyc=%0d got=%0d exp=%0d", cyc, instr_count, e.cnt);
            end
            n_tests++;
            if ((rd && wr) || (inc_pc && load_pc)) begin
                n_fail++;
                $display("FAIL exclusive cyc=%0d rd=%b wr=%b inc_pc=%b load_pc=%b",
                         cyc, rd, wr, inc_pc, load_pc);
            end
        end
    end

    // Apply one cycle of inputs and queue what the DUT must show during it
    task automatic drive(input logic r, input logic e, input logic res, input logic [2:0] opc,
                         input logic z, input logic mr, input logic [2:0] st, input logic [8:0] ctl);
        rst_n     = r;
        ena       = e;
        resume    = res;
        opcode    = opc;
        zero      = z;
        mem_ready = mr;
        sb.push_back('{st: st, ctl: ctl, cnt: m_cnt});
        @(posedge clk);
        #1;
    endtask

    // One instruction starting in F0; wait counts < 0 mark non-memory steps
    task automatic run_instr(input logic [2:0] op, input logic z, input logic ea, input bit abort,
                             input int w0, input int w1, input int we0, input int we1);
        logic [2:0] st_l[$];
        logic [8:0] ctl_l[$];
        int         wt_l[$];
        bit         mem_op;
        mem_op = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
        if (abort) begin
            drive(1'b0, rb(), rb(), 3'($urandom), rb(), 1'b0, 3'd1, mk(1,0,1,0,0,0,0,0,0));
            m_cnt  = '0;
            cur_st = 3'd0;
            return;
        end
        st_l.push_back(3'd1); ctl_l.push_back(mk(1,0,1,0,0,0,0,0,0)); wt_l.push_back(w0);
        st_l.push_back(3'd2); ctl_l.push_back(mk(1,0,1,1,0,0,0,0,0)); wt_l.push_back(w1);
        st_l.push_back(3'd3); ctl_l.push_back(mk(0,0,0,0,0,0,1,0,0)); wt_l.push_back(-1);
        if (op == HLT) begin
            st_l.push_back(3'd4); ctl_l.push_back(mk(0,0,0,0,0,0,0,0,1)); wt_l.push_back(-1);
        end else begin
            st_l.push_back(3'd4);
            st_l.push_back(3'd5);
            st_l.push_back(3'd6);
            if (mem_op) begin
                ctl_l.push_back(mk(1,0,0,0,0,0,0,0,0)); wt_l.push_back(we0);
                ctl_l.push_back(mk(1,0,0,0,0,1,0,0,0)); wt_l.push_back(we1);
            end else if (op == STO) begin
                ctl_l.push_back(mk(0,0,0,0,0,0,0,1,0)); wt_l.push_back(-1);
                ctl_l.push_back(mk(0,1,0,0,0,0,0,1,0)); wt_l.push_back(we1);
            end else if (op == SKZ) begin
                ctl_l.push_back(mk(0,0,0,z,0,0,0,0,0)); wt_l.push_back(-1);
                ctl_l.push_back(mk(0,0,0,z,0,0,0,0,0)); wt_l.push_back(-1);
            end else begin
                ctl_l.push_back(mk(0,0,0,0,1,0,0,0,0)); wt_l.push_back(-1);
                ctl_l.push_back(mk(0,0,0,0,1,0,0,0,0)); wt_l.push_back(-1);
            end
            ctl_l.push_back(mk(0,0,0,0,0,0,0,(op == STO),0)); wt_l.push_back(-1);
        end
        for (int i = 0; i < st_l.size(); i++) begin
            int n;
            n = (wt_l[i] < 0) ? 0 : wt_l[i];
            for (int w = 0; w <= n; w++) begin
                logic mr;
                logic [8:0] c;
                mr = (wt_l[i] < 0) ? rb() : logic'(w == n);
                c  = (wt_l[i] >= 0 && !mr) ? (ctl_l[i] & QUAL_MASK) : ctl_l[i];
                drive(1'b1, (st_l[i] == 3'd6) ? ea : rb(), rb(),
                      (st_l[i] == 3'd3) ? op : 3'($urandom),
                      (st_l[i] == 3'd3) ? z : rb(), mr, st_l[i], c);
            end
            if (st_l[i] == 3'd6 || (st_l[i] == 3'd4 && op == HLT)) m_cnt = m_cnt + CW'(1);
        end
        cur_st = (op == HLT) ? 3'd7 : (ea ? 3'd1 : 3'd0);
    endtask

    task automatic do_instr(input logic [2:0] op, input logic z, input logic ea, input bit abort,
                            input int w0, input int w1, input int we0, input int we1,
                            input int hold, input logic res_ena);
        if (cur_st == 3'd0) begin
            repeat ($urandom_range(0, 2))
                drive(1'b1, 1'b0, rb(), 3'($urandom), rb(), rb(), 3'd0, 9'd0);
            drive(1'b1, 1'b1, rb(), 3'($urandom), rb(), rb(), 3'd0, 9'd0);
            cur_st = 3'd1;
        end
        run_instr(op, z, ea, abort, w0, w1, we0, we1);
        if (cur_st == 3'd7) begin
            repeat (hold)
                drive(1'b1, rb(), 1'b0, 3'($urandom), rb(), rb(), 3'd7, mk(0,0,0,0,0,0,0,0,1));
            drive(1'b1, res_ena, 1'b1, 3'($urandom), rb(), rb(), 3'd7, mk(0,0,0,0,0,0,0,0,1));
            cur_st = res_ena ? 3'd1 : 3'd0;
        end
    endtask

    function automatic int rwait();
        return rb() ? int'($urandom_range(0, 3)) : 0;
    endfunction

    initial begin
        rst_n = 1'b0; ena = 1'b0; resume = 1'b0; opcode = 3'd0; zero = 1'b0; mem_ready = 1'b0;
        m_cnt  = '0;
        cur_st = 3'd0;
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 9'd0);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd0, 9'd0);

        do_instr(ADD, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b1);
        do_instr(STO, 1'b0, 1'b1, 1'b0, 0, 0, 0, 3, 0, 1'b1);
        do_instr(SKZ, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b1);
        do_instr(SKZ, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b1);
        do_instr(HLT, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 10, 1'b1);
        do_instr(LDA, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0, 0, 1'b1);
        do_instr(JMP, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b1);

        for (int k = 0; k < 250; k++) begin
            do_instr(3'($urandom), rb(), logic'($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 15) == 0), rwait(), rwait(), rwait(), rwait(),
                     int'($urandom_range(0, 4)), rb());
        end

        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain leftover=%0d exp=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
